// File: rtl/inert_spi_serf.sv
// SPI responder modelling a 6-axis inertial sensor: 16-bit command frames,
// config registers, and yaw sampling at a fixed output data rate with data-ready INT.
module inert_spi_serf #(
  parameter int         ODR_PERIOD = 1024,
  parameter logic [7:0] WHO_AM_I   = 8'h6A
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  output logic               INT,
  input  logic signed [15:0] yaw_in
);

  // state | meaning
  // IDLE  | SS_n high (or held low since reset), waiting for a select fall
  // SHIFT | frame active, shifting on synced SCLK rises
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int TW = (ODR_PERIOD > 2) ? $clog2(ODR_PERIOD) : 1;
  localparam logic [TW-1:0] ODR_LAST = TW'(ODR_PERIOD - 1);

  state_t        state, state_nxt;
  logic          ss_s1, ss_s2, ss_s3;
  logic          sclk_s1, sclk_s2, sclk_s3;
  logic          mosi_s1, mosi_s2;
  logic          ss_fall, ss_rise, sclk_rise;
  logic [4:0]    bit_cnt;
  logic [15:0]   rx_shft, tx_shft, rx_nxt;
  logic [7:0]    int_cfg, ctrl_g, ctrl_x, rd_data;
  logic [7:0]    int_cfg_nxt;
  logic [15:0]   yaw_q, pend_yaw, sample_val;
  logic          pend, tick, sample_apply;
  logic          commit, wr_en, rd_clr, int_nxt;
  logic [TW-1:0] odr_tmr;

  // Select sync flops reset low so a select already held low at reset release
  // is not mistaken for a fall; only a genuine high-to-low starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s1   <= 1'b0;
      ss_s2   <= 1'b0;
      ss_s3   <= 1'b0;
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_s3 <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      state   <= IDLE;
    end else begin
      ss_s1   <= SS_n;
      ss_s2   <= ss_s1;
      ss_s3   <= ss_s2;
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
      state   <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ss_fall   = 1'b0;
    ss_rise   = 1'b0;
    case (state)
      IDLE:  if (ss_s3 && !ss_s2) begin
               ss_fall   = 1'b1;
               state_nxt = SHIFT;
             end
      SHIFT: if (ss_s2) begin
               ss_rise   = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  assign sclk_rise = (state == SHIFT) && !ss_s2 && sclk_s2 && !sclk_s3;
  assign rx_nxt    = {rx_shft[14:0], mosi_s2};

  always_comb begin
    rd_data = 8'h00;
    case (rx_nxt[6:0])
      7'h0D:   rd_data = int_cfg;
      7'h0F:   rd_data = WHO_AM_I;
      7'h11:   rd_data = ctrl_g;
      7'h14:   rd_data = ctrl_x;
      7'h26:   rd_data = yaw_q[7:0];
      7'h27:   rd_data = yaw_q[15:8];
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rx_shft <= '0;
      tx_shft <= '0;
    end else if (ss_fall) begin
      bit_cnt <= '0;
      rx_shft <= '0;
      tx_shft <= 16'h0000;
    end else if (sclk_rise) begin
      rx_shft <= rx_nxt;
      if (bit_cnt == 5'd7) tx_shft <= {rd_data, 8'h00};
      else                 tx_shft <= tx_shft << 1;
      if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  assign MISO = (state == SHIFT) && tx_shft[15];

  assign commit = ss_rise && (bit_cnt == 5'd16);
  assign wr_en  = commit && !rx_shft[15];
  assign rd_clr = commit && rx_shft[15] && (rx_shft[14:8] == 7'h27);
  assign int_cfg_nxt = (wr_en && rx_shft[14:8] == 7'h0D) ? rx_shft[7:0] : int_cfg;

  assign tick = (ctrl_g != 8'h00) && (odr_tmr == ODR_LAST);
  // A tick landing mid-frame is deferred to the select rise, after the commit.
  assign sample_apply = (tick && state == IDLE && !ss_fall) || (ss_rise && (pend || tick));
  assign sample_val   = tick ? yaw_in : pend_yaw;

  always_comb begin
    int_nxt = INT;
    if (rd_clr || (wr_en && rx_shft[14:8] == 7'h0D && !rx_shft[1])) int_nxt = 1'b0;
    if (sample_apply && int_cfg_nxt[1]) int_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cfg  <= '0;
      ctrl_g   <= '0;
      ctrl_x   <= '0;
      yaw_q    <= '0;
      pend     <= 1'b0;
      pend_yaw <= '0;
      odr_tmr  <= '0;
      INT      <= 1'b0;
    end else begin
      int_cfg <= int_cfg_nxt;
      INT     <= int_nxt;
      if (wr_en && rx_shft[14:8] == 7'h11) ctrl_g <= rx_shft[7:0];
      if (wr_en && rx_shft[14:8] == 7'h14) ctrl_x <= rx_shft[7:0];
      if (sample_apply) yaw_q <= sample_val;
      if (ss_rise) pend <= 1'b0;
      else if (tick && (ss_fall || state == SHIFT)) begin
        pend     <= 1'b1;
        pend_yaw <= yaw_in;
      end
      if (ctrl_g == 8'h00 || odr_tmr == ODR_LAST) odr_tmr <= '0;
      else                                        odr_tmr <= odr_tmr + 1'b1;
    end
  end

endmodule

// File: tb/tb_inert_spi_serf.sv
// Directed bench for inert_spi_serf: register table plus ODR/INT, deferred
// sample, truncated frame, gyro-off and mid-frame reset sequences.
module tb_inert_spi_serf;
  localparam int ODR = 1024;

  logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0;
  logic MISO, INT;
  logic signed [15:0] yaw_in = 16'sh0000;

  int checks = 0, failures = 0;

  inert_spi_serf #(.ODR_PERIOD(ODR), .WHO_AM_I(8'h6A)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .yaw_in(yaw_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    int          nbits;
    logic [15:0] exp;
    bit          chk;
  } vec_t;

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // MISO sampled just before each SCLK rise; int_end is INT just before SS_n rises.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int hold,
                           output logic [15:0] rd, output logic int_end);
    logic [15:0] acc;
    acc  = '0;
    SS_n = 1'b0;
    tick_clk(4 + hold);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      tick_clk(4);
      acc  = {acc[14:0], MISO};
      SCLK = 1'b1;
      tick_clk(4);
    end
    int_end = INT;
    SS_n = 1'b1;
    tick_clk(6);
    check("miso_idle", {15'd0, MISO}, 16'h0000);
    rd = acc;
  endtask

  task automatic wait_int(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick_clk(1);
      if (INT) ok = 1'b1;
    end
  endtask

  vec_t vecs[12];
  logic [15:0] rd;
  logic ie;
  bit ok, seen;

  initial begin
    vecs[0]  = '{16'h0D02, 16, 16'h0000, 1'b0};
    vecs[1]  = '{16'h8D00, 16, 16'h0002, 1'b1};
    vecs[2]  = '{16'h8F00, 16, 16'h006A, 1'b1};
    vecs[3]  = '{16'h8000, 16, 16'h0000, 1'b1};
    vecs[4]  = '{16'h1460, 16, 16'h0000, 1'b0};
    vecs[5]  = '{16'h9400, 16, 16'h0060, 1'b1};
    vecs[6]  = '{16'h0F55, 16, 16'h0000, 1'b0};
    vecs[7]  = '{16'h8F00, 16, 16'h006A, 1'b1};
    vecs[8]  = '{16'h1455, 12, 16'h0000, 1'b0};
    vecs[9]  = '{16'h9400, 16, 16'h0060, 1'b1};
    vecs[10] = '{16'h8F00, 10, 16'h0001, 1'b1};
    vecs[11] = '{16'h2655, 16, 16'h0000, 1'b0};

    tick_clk(3);
    check("rst_miso", {15'd0, MISO}, 16'h0000);
    check("rst_int",  {15'd0, INT},  16'h0000);
    rst_n = 1'b1;
    tick_clk(6);

    for (int v = 0; v < 12; v++) begin
      spi_frame(vecs[v].cmd, vecs[v].nbits, 0, rd, ie);
      if (vecs[v].chk) check($sformatf("vec%0d_%04h", v, vecs[v].cmd), rd, vecs[v].exp);
    end
    spi_frame(16'hA600, 16, 0, rd, ie);
    check("yaw_l_reset", rd, 16'h0000);

    // ODR sampling and INT handshake
    yaw_in = 16'sh1234;
    spi_frame(16'h1160, 16, 0, rd, ie);
    wait_int(ODR + 50, ok);
    check("int_rise", {15'd0, ok}, 16'h0001);
    spi_frame(16'hA600, 16, 0, rd, ie);
    check("yaw_l", rd, 16'h0034);
    check("int_after_a6", {15'd0, INT}, 16'h0001);
    spi_frame(16'hA700, 16, 0, rd, ie);
    check("yaw_h", rd, 16'h0012);
    check("int_before_a7_rise", {15'd0, ie}, 16'h0001);
    check("int_clr_a7", {15'd0, INT}, 16'h0000);

    // truncated write discarded
    spi_frame(16'h1130, 10, 0, rd, ie);
    check("int_trunc", {15'd0, INT}, 16'h0000);
    spi_frame(16'h9100, 16, 0, rd, ie);
    check("ctrl_g_kept", rd, 16'h0060);

    // tick deferred inside a long frame
    wait_int(ODR + 50, ok);
    check("int_rise2", {15'd0, ok}, 16'h0001);
    yaw_in = 16'shBEEF;
    spi_frame(16'hA700, 16, 0, rd, ie);
    check("yaw_h2", rd, 16'h0012);
    check("int_clr2", {15'd0, INT}, 16'h0000);
    spi_frame(16'hA600, 16, ODR + 80, rd, ie);
    check("yaw_l_midframe", rd, 16'h0034);
    check("int_midframe", {15'd0, ie}, 16'h0000);
    check("int_at_rise", {15'd0, INT}, 16'h0001);
    spi_frame(16'hA600, 16, 0, rd, ie);
    check("yaw_l_new", rd, 16'h00EF);
    spi_frame(16'hA700, 16, 0, rd, ie);
    check("yaw_h_new", rd, 16'h00BE);
    check("int_clr3", {15'd0, INT}, 16'h0000);

    // gyro disabled
    spi_frame(16'h1100, 16, 0, rd, ie);
    seen = 1'b0;
    for (int i = 0; i < 5 * ODR; i++) begin
      tick_clk(1);
      if (INT) seen = 1'b1;
    end
    check("int_gyro_off", {15'd0, seen}, 16'h0000);
    spi_frame(16'h9100, 16, 0, rd, ie);
    check("ctrl_g_off", rd, 16'h0000);

    // reset mid-frame
    SS_n = 1'b0;
    tick_clk(4);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0; MOSI = i[0]; tick_clk(4);
      SCLK = 1'b1; tick_clk(4);
    end
    rst_n = 1'b0;
    tick_clk(3);
    rst_n = 1'b1;
    tick_clk(4);
    check("miso_post_rst", {15'd0, MISO}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      SCLK = 1'b0; MOSI = 1'b1; tick_clk(4);
      SCLK = 1'b1; tick_clk(4);
    end
    SS_n = 1'b1;
    tick_clk(6);
    check("miso_ss_high", {15'd0, MISO}, 16'h0000);
    spi_frame(16'h8D00, 16, 0, rd, ie);
    check("int_cfg_post_rst", rd, 16'h0000);
    spi_frame(16'h8F00, 16, 0, rd, ie);
    check("who_post_rst", rd, 16'h006A);
    check("int_post_rst", {15'd0, INT}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
